// File: rtl/exception_dispatcher_pkg.sv
// Shared types and constants for the exception dispatcher and its queue.
package exception_dispatcher_pkg;

  localparam int unsigned DATA_W = 32;

  typedef logic [DATA_W-1:0] Data;

  // Exception codes presented to CP0; EXC_NONE means nothing is being issued.
  typedef enum logic [4:0] {
    EXC_SYS  = 5'd8,
    EXC_BP   = 5'd9,
    EXC_TR   = 5'd13,
    EXC_NONE = 5'd31
  } ExcCodeEnum;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } DispatchState;

  typedef struct packed {
    ExcCodeEnum code;
    Data        pc;
  } ExcEntry;

  // Status register bit positions: global enable and per-cause mask bits.
  localparam int unsigned STATUS_IE_BIT       = 0;
  localparam int unsigned STATUS_SYS_MASK_BIT = 8;
  localparam int unsigned STATUS_BP_MASK_BIT  = 9;
  localparam int unsigned STATUS_TR_MASK_BIT  = 10;

  // An entry is dispatchable when exceptions are globally enabled and its mask bit is clear.
  function automatic logic head_responsive(input ExcEntry e, input Data status);
    logic masked;
    masked = 1'b1;
    case (e.code)
      EXC_SYS: masked = status[STATUS_SYS_MASK_BIT];
      EXC_BP:  masked = status[STATUS_BP_MASK_BIT];
      EXC_TR:  masked = status[STATUS_TR_MASK_BIT];
      default: masked = 1'b1;
    endcase
    return status[STATUS_IE_BIT] && !masked;
  endfunction

endpackage

// File: rtl/exception_dispatcher_if.sv
// Execute-stage / CP0 side signals of the exception dispatcher.
interface exception_dispatcher_if #(
  parameter int unsigned DROP_WIDTH = 8
);
  import exception_dispatcher_pkg::*;

  logic                  enable;
  logic                  sysReq;
  logic                  bpReq;
  logic                  trReq;
  Data                   reqPc;
  Data                   status;
  logic                  cop0Idle;
  logic                  eret;
  ExcCodeEnum            excCode;
  Data                   excPc;
  logic                  flush;
  logic                  busy;
  logic                  overflow;
  logic                  conflict;
  logic [DROP_WIDTH-1:0] dropped;

  // Environment side: drives requests and CP0 status, observes dispatch.
  modport master (
    output enable, sysReq, bpReq, trReq, reqPc, status, cop0Idle, eret,
    input  excCode, excPc, flush, busy, overflow, conflict, dropped
  );

  // Dispatcher side.
  modport slave (
    input  enable, sysReq, bpReq, trReq, reqPc, status, cop0Idle, eret,
    output excCode, excPc, flush, busy, overflow, conflict, dropped
  );

endinterface

// File: rtl/exception_dispatcher_exc_queue.sv
// Synchronous FIFO of pending exceptions; push into a full queue succeeds only alongside a pop.
module exc_queue
  import exception_dispatcher_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    i_en,
  input  logic    i_push,
  input  logic    i_pop,
  input  ExcEntry i_data,
  output logic    o_full,
  output logic    o_empty,
  output ExcEntry o_head
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  ExcEntry     r_mem [DEPTH];
  logic        w_do_push;
  logic        w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_en && i_pop && !o_empty;
  assign w_do_push = i_en && i_push && (!o_full || w_do_pop);
  assign o_head    = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update; the extra MSB distinguishes full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // Entry storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/exception_dispatcher.sv
// Queues execute-stage trap requests, filters them against Status and issues them to CP0 one at a time.
module exception_dispatcher
  import exception_dispatcher_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned DROP_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  exception_dispatcher_if.slave bus
);

  DispatchState          r_state;
  ExcCodeEnum            r_exc_code;
  Data                   r_exc_pc;
  logic                  r_busy;
  logic                  r_overflow;
  logic                  r_conflict;
  logic [DROP_WIDTH-1:0] r_dropped;

  ExcEntry               w_push_entry;
  ExcEntry               w_head;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_any_req;
  logic                  w_multi_req;
  logic                  w_pop;
  logic                  w_head_ok;
  logic                  w_push_drop;
  logic                  w_mask_drop;
  logic [1:0]            w_drop_inc;
  logic [DROP_WIDTH:0]   w_drop_sum;
  logic [DROP_WIDTH-1:0] w_drop_next;
  logic                  w_flush;

  assign w_any_req   = bus.sysReq | bus.bpReq | bus.trReq;
  assign w_multi_req = (bus.sysReq & bus.bpReq) | (bus.sysReq & bus.trReq) |
                       (bus.bpReq & bus.trReq);

  // Highest-priority request wins: Sys > Bp > Tr.
  always_comb begin
    w_push_entry.code = EXC_TR;
    w_push_entry.pc   = bus.reqPc;
    if (bus.sysReq)     w_push_entry.code = EXC_SYS;
    else if (bus.bpReq) w_push_entry.code = EXC_BP;
  end

  exc_queue #(.DEPTH(DEPTH)) u_queue (
    .clk     (clock),
    .rst_n   (reset),
    .i_en    (bus.enable),
    .i_push  (w_any_req),
    .i_pop   (w_pop),
    .i_data  (w_push_entry),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  // In IDLE the head always leaves the queue: either into the issue register or dropped.
  assign w_head_ok   = head_responsive(w_head, bus.status);
  assign w_pop       = (r_state == IDLE) && !w_empty;
  assign w_push_drop = w_any_req && w_full && !w_pop;
  assign w_mask_drop = w_pop && !w_head_ok;

  // Up to two drops per edge (one overflow, one masked head); saturate instead of wrapping.
  assign w_drop_inc  = 2'(w_push_drop) + 2'(w_mask_drop);
  assign w_drop_sum  = {1'b0, r_dropped} + (DROP_WIDTH+1)'(w_drop_inc);
  assign w_drop_next = w_drop_sum[DROP_WIDTH] ? {DROP_WIDTH{1'b1}} : w_drop_sum[DROP_WIDTH-1:0];

  // Flush must coincide with the ISSUE cycle in which CP0 accepts, so it follows cop0Idle directly.
  assign w_flush = (r_state == ISSUE) && bus.cop0Idle && bus.enable;

  // Dispatch FSM, issue register and sticky status.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_exc_code <= EXC_NONE;
      r_exc_pc   <= '0;
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
      r_conflict <= 1'b0;
      r_dropped  <= '0;
    end else if (bus.enable) begin
      r_dropped <= w_drop_next;
      if (w_push_drop) r_overflow <= 1'b1;
      if (w_multi_req) r_conflict <= 1'b1;
      case (r_state)
        IDLE: begin
          if (w_pop && w_head_ok) begin
            r_state    <= ISSUE;
            r_busy     <= 1'b1;
            r_exc_code <= w_head.code;
            r_exc_pc   <= w_head.pc;
          end
        end
        ISSUE: begin
          if (bus.cop0Idle) r_state <= WAIT;
        end
        WAIT: begin
          if (bus.eret) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_exc_code <= EXC_NONE;
            r_exc_pc   <= '0;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_busy     <= 1'b0;
          r_exc_code <= EXC_NONE;
          r_exc_pc   <= '0;
        end
      endcase
    end
  end

  assign bus.excCode  = r_exc_code;
  assign bus.excPc    = r_exc_pc;
  assign bus.flush    = w_flush;
  assign bus.busy     = r_busy;
  assign bus.overflow = r_overflow;
  assign bus.conflict = r_conflict;
  assign bus.dropped  = r_dropped;

endmodule

// File: tb/tb_exception_dispatcher.sv
// Scoreboard bench for exception_dispatcher: expected dispatches queued at stimulus, checked on flush.
module tb_exception_dispatcher;
  import exception_dispatcher_pkg::*;

  logic clock;
  logic reset;
  int   n_total;
  int   n_bad;
  int   exp_dropped;
  ExcEntry sb[$];
  ExcEntry m_exp;

  exception_dispatcher_if #(.DROP_WIDTH(8)) bus ();

  exception_dispatcher #(.DEPTH(4), .DROP_WIDTH(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send(input logic s, input logic b, input logic t, input Data pc);
    bus.sysReq = s;
    bus.bpReq  = b;
    bus.trReq  = t;
    bus.reqPc  = pc;
    cyc();
    bus.sysReq = 1'b0;
    bus.bpReq  = 1'b0;
    bus.trReq  = 1'b0;
  endtask

  task automatic eret_pulse();
    bus.eret = 1'b1;
    cyc();
    bus.eret = 1'b0;
  endtask

  task automatic exp_push(input ExcCodeEnum c, input Data pc);
    ExcEntry e;
    e.code = c;
    e.pc   = pc;
    sb.push_back(e);
  endtask

  task automatic add_drop(input int n);
    exp_dropped = (exp_dropped + n > 255) ? 255 : exp_dropped + n;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_code"},     32'(bus.excCode), 32'(EXC_NONE));
    chk({tag, "_pc"},       bus.excPc, 32'h0);
    chk({tag, "_flush"},    32'(bus.flush), 32'h0);
    chk({tag, "_busy"},     32'(bus.busy), 32'h0);
    chk({tag, "_overflow"}, 32'(bus.overflow), 32'h0);
    chk({tag, "_conflict"}, 32'(bus.conflict), 32'h0);
    chk({tag, "_dropped"},  32'(bus.dropped), 32'h0);
  endtask

  // Every flush pulse must correspond to the oldest expected dispatch.
  always @(negedge clock) begin
    if (reset && bus.flush) begin
      if (sb.size() == 0) begin
        chk("flush_unexpected", 32'h1, 32'h0);
      end else begin
        m_exp = sb.pop_front();
        chk("disp_code", 32'(bus.excCode), 32'(m_exp.code));
        chk("disp_pc", bus.excPc, m_exp.pc);
      end
    end
  end

  initial begin
    n_total     = 0;
    n_bad       = 0;
    exp_dropped = 0;
    reset       = 1'b0;
    bus.enable  = 1'b1;
    bus.sysReq  = 1'b0;
    bus.bpReq   = 1'b0;
    bus.trReq   = 1'b0;
    bus.reqPc   = '0;
    bus.status  = 32'h0000_0001;
    bus.cop0Idle = 1'b1;
    bus.eret    = 1'b0;
    cyc(3);
    chk_reset("rst");
    reset = 1'b1;
    cyc();

    // Single request: visible on excCode in the cycle after the second edge.
    exp_push(EXC_SYS, 32'h0040_0010);
    send(1'b1, 1'b0, 1'b0, 32'h0040_0010);
    chk("t1_lat_e0", 32'(bus.excCode), 32'(EXC_NONE));
    cyc();
    chk("t1_code", 32'(bus.excCode), 32'(EXC_SYS));
    chk("t1_pc", bus.excPc, 32'h0040_0010);
    chk("t1_busy_issue", 32'(bus.busy), 32'h1);
    cyc();
    chk("t1_flush_wait", 32'(bus.flush), 32'h0);
    chk("t1_busy_wait", 32'(bus.busy), 32'h1);
    chk("t1_code_wait", 32'(bus.excCode), 32'(EXC_SYS));
    eret_pulse();
    chk("t1_code_after_eret", 32'(bus.excCode), 32'(EXC_NONE));
    chk("t1_pc_after_eret", bus.excPc, 32'h0);
    chk("t1_busy_after_eret", 32'(bus.busy), 32'h0);

    // CP0 stall: ISSUE held while cop0Idle is low; an eret here is ignored.
    bus.cop0Idle = 1'b0;
    exp_push(EXC_SYS, 32'h0040_0020);
    send(1'b1, 1'b0, 1'b0, 32'h0040_0020);
    cyc();
    for (int i = 0; i < 3; i++) begin
      chk("t2_stall_code", 32'(bus.excCode), 32'(EXC_SYS));
      chk("t2_stall_pc", bus.excPc, 32'h0040_0020);
      chk("t2_stall_flush", 32'(bus.flush), 32'h0);
      if (i == 1) bus.eret = 1'b1;
      cyc();
      bus.eret = 1'b0;
    end
    chk("t2_still_issue", 32'(bus.busy), 32'h1);
    bus.cop0Idle = 1'b1;
    cyc();
    chk("t2_busy_wait", 32'(bus.busy), 32'h1);
    chk("t2_flush_wait", 32'(bus.flush), 32'h0);
    eret_pulse();
    chk("t2_busy_idle", 32'(bus.busy), 32'h0);

    // Masking: Sys masked by status[8] is dropped, Bp still dispatches.
    bus.status = 32'h0000_0101;
    send(1'b1, 1'b0, 1'b0, 32'h0000_0500);
    cyc();
    add_drop(1);
    chk("t3_dropped", 32'(bus.dropped), 32'(exp_dropped));
    chk("t3_busy", 32'(bus.busy), 32'h0);
    chk("t3_code", 32'(bus.excCode), 32'(EXC_NONE));
    exp_push(EXC_BP, 32'h0000_0504);
    send(1'b0, 1'b1, 1'b0, 32'h0000_0504);
    cyc();
    chk("t3_bp_code", 32'(bus.excCode), 32'(EXC_BP));
    cyc();
    eret_pulse();

    // Global disable: every request dropped, never busy.
    bus.status = 32'h0000_0000;
    send(1'b1, 1'b0, 1'b0, 32'h0000_0520);
    chk("t4_busy_a", 32'(bus.busy), 32'h0);
    send(1'b0, 1'b1, 1'b0, 32'h0000_0524);
    chk("t4_busy_b", 32'(bus.busy), 32'h0);
    send(1'b0, 1'b0, 1'b1, 32'h0000_0528);
    cyc();
    add_drop(3);
    chk("t4_dropped", 32'(bus.dropped), 32'(exp_dropped));
    chk("t4_busy_c", 32'(bus.busy), 32'h0);

    // Overflow and ordering: fill the queue during WAIT.
    bus.status = 32'h0000_0001;
    exp_push(EXC_SYS, 32'h0000_0600);
    send(1'b1, 1'b0, 1'b0, 32'h0000_0600);
    cyc(2);
    chk("t5_in_wait", 32'(bus.busy), 32'h1);
    for (int i = 0; i < 5; i++) begin
      if (i < 4) exp_push(EXC_TR, 32'(32'h100 + 4 * i));
      send(1'b0, 1'b0, 1'b1, 32'(32'h100 + 4 * i));
    end
    add_drop(1);
    chk("t5_overflow", 32'(bus.overflow), 32'h1);
    chk("t5_dropped", 32'(bus.dropped), 32'(exp_dropped));
    for (int i = 0; i < 5; i++) begin
      eret_pulse();
      chk("t5_idle_code", 32'(bus.excCode), 32'(EXC_NONE));
      if (i == 0) begin
        // Push into a full queue on the same edge as a pop is accepted.
        exp_push(EXC_TR, 32'h0000_0114);
        send(1'b0, 1'b0, 1'b1, 32'h0000_0114);
      end else begin
        cyc();
      end
      chk("t5_order_code", 32'(bus.excCode), 32'(EXC_TR));
      chk("t5_order_pc", bus.excPc, (i < 4) ? 32'(32'h100 + 4 * i) : 32'h0000_0114);
      cyc();
    end
    eret_pulse();
    chk("t5_busy_done", 32'(bus.busy), 32'h0);
    chk("t5_dropped_after", 32'(bus.dropped), 32'(exp_dropped));

    // Conflict, then async reset while in ISSUE.
    bus.cop0Idle = 1'b0;
    chk("t6_conflict_pre", 32'(bus.conflict), 32'h0);
    exp_push(EXC_SYS, 32'h0000_0700);
    send(1'b1, 1'b0, 1'b1, 32'h0000_0700);
    chk("t6_conflict", 32'(bus.conflict), 32'h1);
    cyc();
    chk("t6_code", 32'(bus.excCode), 32'(EXC_SYS));
    chk("t6_pc", bus.excPc, 32'h0000_0700);
    #2;
    reset = 1'b0;
    #1;
    chk_reset("t6_async");
    sb.delete();
    exp_dropped = 0;
    bus.cop0Idle = 1'b1;
    cyc(2);
    reset = 1'b1;
    cyc();
    chk("t6_post_busy", 32'(bus.busy), 32'h0);

    // Enable low: requests and state updates are held off.
    bus.enable = 1'b0;
    send(1'b1, 1'b0, 1'b0, 32'h0000_0900);
    cyc();
    chk("t7_busy", 32'(bus.busy), 32'h0);
    chk("t7_code", 32'(bus.excCode), 32'(EXC_NONE));
    bus.enable = 1'b1;
    cyc(2);
    chk("t7_busy_after", 32'(bus.busy), 32'h0);

    // Dropped counter saturates.
    bus.status = 32'h0000_0000;
    for (int i = 0; i < 260; i++) send(1'b1, 1'b0, 1'b0, 32'(i));
    cyc();
    add_drop(260);
    chk("t8_dropped_sat", 32'(bus.dropped), 32'(exp_dropped));

    // Recovery dispatch after all of the above.
    bus.status = 32'h0000_0001;
    exp_push(EXC_BP, 32'h0000_0A00);
    send(1'b0, 1'b1, 1'b0, 32'h0000_0A00);
    cyc(2);
    eret_pulse();
    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/exception_dispatcher.md
Name: exception_dispatcher

Overview:
- Producer side of the exception interface that CP0 consumes.
- Collects trap requests (syscall, break, trap) raised by the execute stage and queues them with the faulting PC.
- Filters each request against a mirror of the CP0 Status register.
- Presents one exception at a time on the excCode/pc lines CP0 samples, flushes the pipeline, then holds off further dispatch until CP0 executes ERET.

Parameters:
- DEPTH, 4, queue entries; power of two, at least 2.
- DROP_WIDTH, 8, width of the saturating dropped-request counter.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  global advance; when low, all registers hold (reset still acts).
- sysReq  input  1  SYSCALL retired this cycle.
- bpReq  input  1  BREAK retired this cycle.
- trReq  input  1  trap condition true this cycle.
- reqPc  input  Data  PC of the requesting instruction.
- status  input  Data  mirror of CP0 Status (reg 12).
- cop0Idle  input  1  CP0 opCode is NONE this cycle.
- eret  input  1  CP0 executes ERET this cycle.
- excCode  output  ExcCodeEnum  code presented to CP0; ExcCode::None when not issuing.
- excPc  output  Data  PC presented to CP0; '0 when not issuing.
- flush  output  1  one-cycle pipeline flush pulse.
- busy  output  1  high in ISSUE and WAIT.
- overflow  output  1  sticky; set when a request meets a full queue.
- conflict  output  1  sticky; set when more than one request is high in one cycle.
- dropped  output  DROP_WIDTH  saturating count of masked or overflowed requests.

Behaviour:
- Reset values: queue empty, state IDLE, excCode = None, excPc = 0, flush/busy/overflow/conflict = 0, dropped = 0.
- Every update below happens only on edges where enable = 1.
- Enqueue:
  - At an edge with any request high, push {code, reqPc}.
  - Priority when several are high: Sys > Bp > Tr. The lower-priority requests are discarded and conflict is set.
- Full queue:
  - A push into a full queue is discarded, overflow is set, and dropped increments.
  - If the same edge also pops, the push succeeds.
- Mask test on the queue head:
  - The head is responsive iff status[0] = 1 and its mask bit is 0: Sys uses status[8], Bp status[9], Tr status[10]. A zero mask bit enables the exception.
  - A non-responsive head in IDLE is popped at the next edge and dropped increments; the state stays IDLE.
- State machine:
  - IDLE -> ISSUE: at the edge where the head is responsive. The head is popped into an issue register.
  - ISSUE: excCode and excPc are driven from the issue register.
  - ISSUE -> WAIT: at the edge where cop0Idle = 1. flush is high for exactly that ISSUE cycle.
  - ISSUE with cop0Idle = 0: stays in ISSUE, outputs held, flush low.
  - WAIT -> IDLE: at the edge where eret = 1. excCode returns to None.
  - eret in IDLE or ISSUE is ignored.
- Latency: request at edge e0 -> head visible after e0 -> ISSUE entered at e1 -> excCode valid in the cycle after e1. Minimum 2 edges.
- Back-to-back dispatch: the earliest next ISSUE is 1 edge after ERET, since the queue was filling during WAIT.
- The queue keeps accepting requests in every state.
- dropped saturates at all-ones; it never wraps.
- Asynchronous reset in any state immediately clears everything to the reset values, including mid-ISSUE. No partial exception is left on excCode.

Decomposition:
- Shared package (alongside ExcCode/Parameter):
  - DispatchState enum {IDLE, ISSUE, WAIT}.
  - ExcEntry packed struct {ExcCodeEnum code; Data pc}.
  - Localparams for the Status mask bit positions (8, 9, 10) and the enable bit (0).
- Sub-module exc_queue:
  - Parameterised synchronous FIFO of ExcEntry with push, pop, full, empty, head.
  - Simultaneous push and pop when full is legal.
  - The dispatcher owns the FSM, mask test and counters.

Test Plan:
- Single request: reset release; status = 0x0000_0001; sysReq at pc 0x0040_0010; cop0Idle = 1 -> excCode = Sys, excPc = 0x0040_0010 two edges later; flush for 1 cycle; busy until eret; then excCode = None.
- CP0 stall: as above but cop0Idle = 0 for 3 cycles -> ISSUE held 3 extra cycles with stable excCode/excPc; flush only in the cop0Idle = 1 cycle.
- Masking: status = 0x0000_0101; sysReq -> no ISSUE, dropped = 1. Then bpReq -> dispatched as Bp.
- Global disable: status[0] = 0; 3 requests -> all dropped, dropped = 3, busy stays 0.
- Overflow and order:
  - 5 trReq with pc 0x100..0x110 while in WAIT, DEPTH = 4 -> overflow = 1, dropped = 1.
  - After successive erets, the dispatched PCs are 0x100, 0x104, 0x108, 0x10C in order.
- Conflict and reset:
  - sysReq and trReq together -> Sys queued, conflict = 1.
  - Reset pulled low in ISSUE -> all outputs read reset values before the next clock edge.
